// File: rtl/mem_arbiter_rr_pkg.sv
// mem_arbiter_rr_pkg
//   Constants shared by the shared-memory arbiter slice.
//   ARB_TDM / ARB_RR       : values of the ARB_MODE parameter.
//   DEFAULT_SHARED_LIMIT   : highest address of the shared window; core
//                            addresses above it are private and get
//                            relocated by core index.
package mem_arbiter_rr_pkg;

  localparam int ARB_TDM = 0;
  localparam int ARB_RR  = 1;

  localparam int DEFAULT_SHARED_LIMIT = 3499;

endpackage : mem_arbiter_rr_pkg

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin selector: returns the first set bit of req
//   found searching upward from (ptr + 1), wrapping at N.
//   Ports:
//     req   in  N      request vector (already masked by the caller)
//     ptr   in  IDX_W  index of the previous winner
//     win   out N      one-hot winner
//     valid out 1      at least one request was set
module rr_pick #(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     win,
  output logic             valid
);

  always_comb begin
    int               pos;
    logic [IDX_W-1:0] idx;
    // NOTE: every output of a combinational block gets a default before any
    // conditional logic, otherwise untaken paths infer latches.
    win   = '0;
    valid = 1'b0;
    pos   = 0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      idx = IDX_W'(pos);
      if (!valid && req[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule : rr_pick

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr
//   Shares one single-port memory between NUM_CORES cores. One access is
//   issued per cycle, either by work-conserving round-robin or by fixed TDM
//   slots. Private addresses (above SHARED_LIMIT) are relocated by adding
//   the core index. Read data returns through a tag pipeline matching the
//   memory latency and is steered to the requesting core's rdata slice.
//   Ports:
//     clk16, rst_n          clock (rising edge), async active-low reset
//     req/we                per-core request level and write enable
//     addr/wdata            per-core address and write data (slice i = core i)
//     gnt                   one-cycle pulse: request accepted
//     rvalid/rdata          one-cycle read-return pulse, data held per core
//     mem_addr/mem_we/mem_wdata  registered memory command
//     mem_rdata             memory read data, RD_LAT cycles after mem_addr
module mem_arbiter_rr
  import mem_arbiter_rr_pkg::*;
#(
  parameter int NUM_CORES    = 8,
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 16,
  parameter int SHARED_LIMIT = DEFAULT_SHARED_LIMIT,
  parameter int RD_LAT       = 1,
  parameter int ARB_MODE     = ARB_RR
) (
  input  logic                          clk16,
  input  logic                          rst_n,
  input  logic [NUM_CORES-1:0]          req,
  input  logic [NUM_CORES-1:0]          we,
  input  logic [NUM_CORES*ADDR_W-1:0]   addr,
  input  logic [NUM_CORES*DATA_W-1:0]   wdata,
  output logic [NUM_CORES-1:0]          gnt,
  output logic [NUM_CORES-1:0]          rvalid,
  output logic [NUM_CORES*DATA_W-1:0]   rdata,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          mem_we,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata
);

  localparam int                IDX_W     = $clog2(NUM_CORES);
  localparam logic [ADDR_W-1:0] LIMIT     = ADDR_W'(SHARED_LIMIT);
  localparam logic [IDX_W-1:0]  LAST_CORE = IDX_W'(NUM_CORES - 1);

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] core;
  } tag_t;

  logic [IDX_W-1:0]     last_win;
  logic [IDX_W-1:0]     slot;
  logic [IDX_W-1:0]     gnt_idx;   // index of the core granted this cycle
  logic [NUM_CORES-1:0] elig;
  logic [NUM_CORES-1:0] win_oh;
  logic                 win_vld;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_we;
  logic [ADDR_W-1:0]    win_addr;
  logic [DATA_W-1:0]    win_wdata;
  logic [ADDR_W-1:0]    phys_addr;
  tag_t                 tag_pipe [RD_LAT];
  tag_t                 tag_out;

  // A core whose gnt is high this cycle is still presenting the request it
  // was just granted for, so it is masked out. TDM further limits the
  // candidates to the core owning the current slot; with at most one bit
  // left, the round-robin picker simply returns it.
  always_comb begin
    elig = req & ~gnt;
    if (ARB_MODE == ARB_TDM) elig = elig & (NUM_CORES'(1) << slot);
  end

  rr_pick #(.N(NUM_CORES)) u_pick (
    .req   (elig),
    .ptr   (last_win),
    .win   (win_oh),
    .valid (win_vld)
  );

  // One-hot winner to index, and mux of its command fields.
  always_comb begin
    win_idx   = '0;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (win_oh[i]) begin
        win_idx   = IDX_W'(i);
        win_we    = we[i];
        win_addr  = addr[i*ADDR_W +: ADDR_W];
        win_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
    phys_addr = (win_addr > LIMIT) ? win_addr + ADDR_W'(win_idx) : win_addr;
  end

  // Issue stage: registered memory command and grant.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      gnt_idx   <= '0;
      last_win  <= LAST_CORE;
      slot      <= '0;
    end else begin
      gnt    <= win_vld ? win_oh : '0;
      mem_we <= win_vld & win_we;
      if (win_vld) begin
        mem_addr  <= phys_addr;
        mem_wdata <= win_wdata;
        gnt_idx   <= win_idx;
        last_win  <= win_idx;
      end
      slot <= (slot == LAST_CORE) ? '0 : slot + IDX_W'(1);
    end
  end

  // Read tag pipeline. A read issued while gnt is high has its data on
  // mem_rdata RD_LAT cycles later, exactly when its tag leaves the last stage.
  assign tag_out = tag_pipe[RD_LAT-1];

  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the tag stages are reset explicitly: a stale valid tag left
      // over from before reset would produce a spurious rvalid afterwards.
      for (int k = 0; k < RD_LAT; k++) tag_pipe[k] <= '0;
    end else begin
      tag_pipe[0] <= '{vld: (|gnt) & ~mem_we, core: gnt_idx};
      for (int k = 1; k < RD_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  // Return stage: steer memory data to the tagged core's slice.
  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        rvalid[i] <= tag_out.vld && (tag_out.core == IDX_W'(i));
        if (tag_out.vld && (tag_out.core == IDX_W'(i)))
          rdata[i*DATA_W +: DATA_W] <= mem_rdata;
      end
    end
  end

endmodule : mem_arbiter_rr
